// File: rtl/count_seq_pkg.sv
// Shared state encodings and default widths for the count sequencer.
// Build option: COUNT_SEQ_AUTORELOAD_EN (see count_sequencer.sv).
package count_seq_pkg;

    localparam int unsigned DefaultCountW    = 4;
    localparam int unsigned DefaultPrescaleW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic is_busy_state(input state_e st);
        return (st == StRun) || (st == StHold);
    endfunction

endpackage

// File: rtl/count_seq_prescaler.sv
// Reloadable down-counter: ticks when enabled at zero, then reloads from load_value.
// Build option: none (COUNT_SEQ_AUTORELOAD_EN only affects count_sequencer).
module count_seq_prescaler
    import count_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DefaultPrescaleW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] load_value,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] value_q;
    logic [PRESCALE_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_value;
        end else if (enable) begin
            value_d = (value_q == '0) ? load_value : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign tick = enable && (value_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/clear controlled counter stepped by a prescaler, with terminal-count pulse.
// Build option: define COUNT_SEQ_AUTORELOAD_EN to wrap to zero and keep running at terminal count.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DefaultPrescaleW,
    parameter int unsigned COUNT_W    = DefaultCountW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [COUNT_W-1:0]    limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [COUNT_W-1:0]    counter_out,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    state_e                state_q;
    state_e                state_d;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    count_d;
    logic [COUNT_W-1:0]    limit_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  load;
    logic                  run_en;
    logic                  tick;
    logic                  terminal;

    // Start loads the prescaler straight from the port; later reloads use the latched copy.
    count_seq_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .enable     (run_en),
        .load_value (load ? prescale : prescale_q),
        .tick       (tick)
    );

    assign terminal = tick && (count_q == limit_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop only matters in RUN, start is ignored in RUN
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run_en  = 1'b0;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StHold;
                    end else begin
                        run_en = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                        state_d = StRun;
`else
                        if (terminal) begin
                            state_d = StDone;
                        end
`endif
                    end
                end
                StHold: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Registered-output next values
    always_comb begin
        busy_d = is_busy_state(state_d);
        done_d = run_en && terminal;
    end

    always_comb begin
        count_d = count_q;
        if (clear || load) begin
            count_d = '0;
        end else if (run_en && tick) begin
            if (terminal) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
                count_d = '0;
`else
                count_d = count_q;
`endif
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                limit_q    <= limit;
                prescale_q <= prescale;
            end
        end
    end

    assign counter_out = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: a cycle model pushes expected outputs per driven cycle.
// Build option: COUNT_SEQ_AUTORELOAD_EN selects the wrap-around expectations.
module tb_count_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] limit;
    logic [7:0] prescale;
    logic [3:0] counter_out;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [1:0] st;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [1:0] m_st;
    logic [3:0] m_cnt;
    logic [7:0] m_pre;
    logic [3:0] m_lim;
    logic [7:0] m_ps;
    logic       m_done;
    logic       m_busy;

    count_sequencer #(
        .PRESCALE_W (8),
        .COUNT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .limit       (limit),
        .prescale    (prescale),
        .counter_out (counter_out),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 2'd0; m_cnt = '0; m_pre = '0; m_lim = '0; m_ps = '0; m_done = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (clear) begin
            m_st = 2'd0; m_cnt = '0; m_pre = '0;
        end else begin
            case (m_st)
                2'd0, 2'd3: begin
                    if (start) begin
                        m_lim = limit; m_ps = prescale; m_cnt = '0; m_pre = prescale; m_st = 2'd1;
                    end else begin
                        m_st = 2'd0;
                    end
                end
                2'd1: begin
                    if (stop) begin
                        m_st = 2'd2;
                    end else if (m_pre == 8'd0) begin
                        m_pre = m_ps;
                        if (m_cnt == m_lim) begin
                            m_done = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                            m_cnt = '0;
`else
                            m_st = 2'd3;
`endif
                        end else begin
                            m_cnt = m_cnt + 4'd1;
                        end
                    end else begin
                        m_pre = m_pre - 8'd1;
                    end
                end
                default: if (start) m_st = 2'd1;
            endcase
        end
        m_busy = (m_st == 2'd1) || (m_st == 2'd2);
    endtask

    // Drive one cycle of inputs, predict, then compare just after the edge.
    task automatic cycle(input logic s, input logic p, input logic c);
        exp_t e;
        start = s; stop = p; clear = c;
        model_step();
        e.st = m_st; e.cnt = m_cnt; e.busy = m_busy; e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq("state", state, e.st);
            check_eq("count", counter_out, e.cnt);
            check_eq("busy", busy, e.busy);
            check_eq("done", done, e.done);
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int n;
        int last_done;
        bit seen;
        n_checks = 0; n_fail = 0;
        start = 0; stop = 0; clear = 0; limit = '0; prescale = '0;
        reset = 1'b1;
        model_reset();
        #2;
        check_eq("rst_state", state, 0);
        check_eq("rst_count", counter_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 1, 0);

        // P=0, L=3: counts 0..3 on consecutive RUN cycles, then DONE, then IDLE
        limit = 4'd3; prescale = 8'd0;
        cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("p0_cnt", counter_out, i);
            check_eq("p0_run", state, 1);
            cycle(0, 0, 0);
        end
        check_eq("p0_done", done, 1);
        check_eq("p0_dstate", state, 3);
        check_eq("p0_hold3", counter_out, 3);
        cycle(0, 0, 0);
        check_eq("p0_idle", state, 0);
        check_eq("p0_done_low", done, 0);

        // P=2, L=1: done six cycles after entering RUN
        limit = 4'd1; prescale = 8'd2;
        cycle(1, 0, 0);
        limit = 4'd9; prescale = 8'd7;  // must not affect the running sequence
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            cycle(0, 0, 0);
            n++;
            if (done) seen = 1;
        end
        check_eq("p2_latency", n, 6);
        cycle(0, 0, 0);

        // Stop at count 2 with P=1, hold 5 cycles, resume with the same phase
        limit = 4'd5; prescale = 8'd1;
        cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        check_eq("hold_pre_cnt", counter_out, 2);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0);
            check_eq("hold_state", state, 2);
            check_eq("hold_cnt", counter_out, 2);
        end
        cycle(1, 0, 0);
        check_eq("resume_state", state, 1);
        cycle(0, 0, 0);
        check_eq("resume_phase_a", counter_out, 2);
        cycle(0, 0, 0);
        check_eq("resume_phase_b", counter_out, 3);
        n = 0;
        while (state != 2'd0 && n < 30) begin
            cycle(0, 0, 0);
            n++;
        end
        check_eq("resume_finish", state, 0);

        // clear + stop + start together in RUN
        limit = 4'd7; prescale = 8'd0;
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 1, 1);
        check_eq("clr_state", state, 0);
        check_eq("clr_cnt", counter_out, 0);
        check_eq("clr_done", done, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);

        // L=15, P=0
        limit = 4'd15; prescale = 8'd0;
        cycle(1, 0, 0);
`ifdef COUNT_SEQ_AUTORELOAD_EN
        last_done = -1;
        for (int i = 1; i <= 48; i++) begin
            cycle(0, 0, 0);
            check_eq("ar_busy", busy, 1);
            if (done) begin
                if (last_done >= 0) check_eq("ar_period", i - last_done, 16);
                check_eq("ar_wrap", counter_out, 0);
                last_done = i;
            end
        end
        check_eq("ar_seen", last_done, 48);
        cycle(0, 0, 1);
`else
        last_done = -1;
        for (int i = 1; i <= 17; i++) begin
            cycle(0, 0, 0);
            if (done) last_done = i;
        end
        check_eq("l15_done_at", last_done, 16);
        check_eq("l15_idle", state, 0);
`endif

        // Async reset between edges at count 5
        limit = 4'd9; prescale = 8'd0;
        cycle(1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        check_eq("ar5_cnt", counter_out, 5);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("arst_state", state, 0);
        check_eq("arst_cnt", counter_out, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0);

        // Randomised mix of controls against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) begin
                limit = 4'($urandom_range(15));
                prescale = 8'($urandom_range(3));
            end
            cycle(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
